rfm_cnt_table: RTL and testbench

Parametrised successor to the 64-entry counter CAM. Tracks per-row ACT counts for RFM/TRR (Misra-Gries style) in an ENTRIES-deep table with a spillover counter. Runs a multi-cycle max search that returns both the value and the location of the maximum. Sits between the ACT command monitor and the RFM scheduler, which reads the hottest row and clears its entry after mitigation.

---
 rtl/rfm_pkg.sv | 27 ++
 rtl/rfm_cnt_table_cnt_max_tree.sv | 48 ++++
 rtl/rfm_cnt_table.sv | 251 +++++++++++++++++++++++++
 tb/tb_rfm_cnt_table.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfm_pkg.sv
// ----------------------------------------------------------------------------
// rfm_pkg
// Shared definitions for the RFM/TRR activation counter table: default widths,
// the default alarm threshold, the max-search FSM state encoding and the
// table entry record.
// ----------------------------------------------------------------------------
package rfm_pkg;

   localparam int ENTRIES_DEF = 64;
   localparam int ROW_W_DEF   = 17;
   localparam int CNT_W_DEF   = 16;
   localparam int LANES_DEF   = 16;
   localparam logic [15:0] THRESH_DEF = 16'd4096;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_e;

   // One tracked row at the default widths.
   typedef struct packed {
      logic                 valid;
      logic [ROW_W_DEF-1:0] row;
      logic [CNT_W_DEF-1:0] cnt;
   } entry_t;

endpackage

// File: rtl/rfm_cnt_table_cnt_max_tree.sv
// ----------------------------------------------------------------------------
// cnt_max_tree
// Combinational LANES-input argmax. Returns the largest count and its lane
// index; on equal counts the lower lane index wins.
// Ports:
//   cnt_i     : LANES counts to compare (lane 0 first)
//   max_cnt_o : largest count
//   max_idx_o : lane index of the largest count
// LANES must be a power of two (>= 2).
// ----------------------------------------------------------------------------
module cnt_max_tree
   import rfm_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int LIDX_W = $clog2(LANES_DEF)
) (
   input  logic [CNT_W-1:0]  cnt_i [LANES],
   output logic [CNT_W-1:0]  max_cnt_o,
   output logic [LIDX_W-1:0] max_idx_o
);

   localparam int LVLS = $clog2(LANES);

   genvar gl, gi;
   generate
      for (gl = 0; gl <= LVLS; gl++) begin : g_lvl
         for (gi = 0; gi < (LANES >> gl); gi++) begin : g_node
            logic [CNT_W-1:0]  c;
            logic [LIDX_W-1:0] x;
            if (gl == 0) begin : g_leaf
               assign c = cnt_i[gi];
               assign x = LIDX_W'(gi);
            end else begin : g_cmp
               // Left child always holds the lower indices, so it keeps ties.
               logic right_wins;
               assign right_wins = g_lvl[gl-1].g_node[2*gi+1].c > g_lvl[gl-1].g_node[2*gi].c;
               assign c = right_wins ? g_lvl[gl-1].g_node[2*gi+1].c : g_lvl[gl-1].g_node[2*gi].c;
               assign x = right_wins ? g_lvl[gl-1].g_node[2*gi+1].x : g_lvl[gl-1].g_node[2*gi].x;
            end
         end
      end
   endgenerate

   assign max_cnt_o = g_lvl[LVLS].g_node[0].c;
   assign max_idx_o = g_lvl[LVLS].g_node[0].x;

endmodule

// File: rtl/rfm_cnt_table.sv
// ----------------------------------------------------------------------------
// rfm_cnt_table
// Misra-Gries style per-row ACT counter table with a spillover counter and a
// multi-cycle max search (LANES entries per cycle) for the RFM scheduler.
// Ports:
//   clk, rstn                : clock, async active-low reset
//   act_valid/act_row        : observed ACT; act_ready = ~max_busy
//   max_req                  : start a max search (sampled when idle)
//   max_busy                 : search in progress (table frozen)
//   max_valid                : one-cycle pulse, result registers updated
//   max_cnt/max_idx/max_row  : hottest entry found by the last search
//   clr_en/clr_idx/clr_ready : zero one entry's count; clr_ready = ~max_busy
//   spill_cnt                : spillover counter
//   alarm                    : some valid entry has cnt >= THRESH
// ----------------------------------------------------------------------------
module rfm_cnt_table
   import rfm_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int ROW_W   = ROW_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int LANES   = LANES_DEF,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter logic [CNT_W-1:0] THRESH = CNT_W'(THRESH_DEF)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             act_valid,
   input  logic [ROW_W-1:0] act_row,
   output logic             act_ready,
   input  logic             max_req,
   output logic             max_busy,
   output logic             max_valid,
   output logic [CNT_W-1:0] max_cnt,
   output logic [IDX_W-1:0] max_idx,
   output logic [ROW_W-1:0] max_row,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   output logic             clr_ready,
   output logic [CNT_W-1:0] spill_cnt,
   output logic             alarm
);

   localparam int NPASS  = ENTRIES / LANES;
   localparam int GRP_W  = (NPASS > 1) ? $clog2(NPASS) : 1;
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic             valid_q [ENTRIES];
   logic             valid_d [ENTRIES];
   logic [ROW_W-1:0] row_q   [ENTRIES];
   logic [ROW_W-1:0] row_d   [ENTRIES];
   logic [CNT_W-1:0] cnt_q   [ENTRIES];
   logic [CNT_W-1:0] cnt_d   [ENTRIES];
   logic [CNT_W-1:0] cnt_clr [ENTRIES];
   logic [CNT_W-1:0] spill_q, spill_d;
   logic             alarm_q, alarm_d;

   state_e           state_q, state_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             max_valid_q, max_valid_d;
   logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
   logic [IDX_W-1:0] max_idx_q, max_idx_d;
   logic [ROW_W-1:0] max_row_q, max_row_d;

   logic             busy, act_fire, clr_fire;
   logic             hit, free, vict;
   logic [IDX_W-1:0] hit_idx, free_idx, vict_idx;
   logic [CNT_W-1:0] spill_inc, hit_cnt;

   assign busy     = (state_q == ST_SCAN);
   assign act_fire = act_valid & ~busy;
   assign clr_fire = clr_en & ~busy;

   // ---------------- table update ----------------
   always_comb begin
      spill_inc = (spill_q == '1) ? spill_q : spill_q + CNT_W'(1);
      hit      = 1'b0;
      free     = 1'b0;
      vict     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      vict_idx = '0;
      // Clear first; the ACT is evaluated against the cleared counts.
      for (int i = 0; i < ENTRIES; i++) begin
         cnt_clr[i] = (clr_fire && clr_idx == IDX_W'(i)) ? '0 : cnt_q[i];
      end
      // Descending scan so the last write is the lowest matching index.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && row_q[i] == act_row) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (valid_q[i] && cnt_clr[i] == spill_q) begin
            vict     = 1'b1;
            vict_idx = IDX_W'(i);
         end
      end
      hit_cnt = (cnt_clr[hit_idx] == '1) ? cnt_clr[hit_idx] : cnt_clr[hit_idx] + CNT_W'(1);

      valid_d = valid_q;
      row_d   = row_q;
      cnt_d   = cnt_clr;
      spill_d = spill_q;
      if (act_fire) begin
         if (hit) begin
            cnt_d[hit_idx] = hit_cnt;
         end else if (free) begin
            valid_d[free_idx] = 1'b1;
            row_d[free_idx]   = act_row;
            cnt_d[free_idx]   = spill_inc;
         end else if (vict) begin
            // Victim search only matters when no entry is free (table full).
            row_d[vict_idx] = act_row;
            cnt_d[vict_idx] = spill_inc;
         end else begin
            spill_d = spill_inc;
         end
      end

      alarm_d = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_d[i] && cnt_d[i] >= THRESH) begin
            alarm_d = 1'b1;
         end
      end
   end

   // ---------------- max search datapath ----------------
   logic [CNT_W-1:0]  lane_cnt [LANES];
   logic [CNT_W-1:0]  tree_cnt;
   logic [LIDX_W-1:0] tree_lidx;
   logic [IDX_W-1:0]  tree_gidx;
   logic [CNT_W-1:0]  cand_cnt;
   logic [IDX_W-1:0]  cand_idx;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [IDX_W-1:0] eidx;
         assign eidx         = IDX_W'(int'(grp_q) * LANES + gi);
         assign lane_cnt[gi] = valid_q[eidx] ? cnt_q[eidx] : '0;
      end
   endgenerate

   cnt_max_tree #(
      .LANES  (LANES),
      .CNT_W  (CNT_W),
      .LIDX_W (LIDX_W)
   ) u_tree (
      .cnt_i     (lane_cnt),
      .max_cnt_o (tree_cnt),
      .max_idx_o (tree_lidx)
   );

   assign tree_gidx = IDX_W'(int'(grp_q) * LANES + int'(tree_lidx));

   always_comb begin
      state_d     = state_q;
      grp_d       = grp_q;
      best_cnt_d  = best_cnt_q;
      best_idx_d  = best_idx_q;
      max_valid_d = 1'b0;
      max_cnt_d   = max_cnt_q;
      max_idx_d   = max_idx_q;
      max_row_d   = max_row_q;
      // Strictly greater: earlier groups keep ties.
      if (tree_cnt > best_cnt_q) begin
         cand_cnt = tree_cnt;
         cand_idx = tree_gidx;
      end else begin
         cand_cnt = best_cnt_q;
         cand_idx = best_idx_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (max_req) begin
               state_d    = ST_SCAN;
               grp_d      = '0;
               best_cnt_d = '0;
               best_idx_d = '0;
            end
         end
         ST_SCAN: begin
            if (grp_q == GRP_W'(NPASS - 1)) begin
               state_d     = ST_IDLE;
               max_valid_d = 1'b1;
               max_cnt_d   = cand_cnt;
               max_idx_d   = cand_idx;
               max_row_d   = row_q[cand_idx];
            end else begin
               best_cnt_d = cand_cnt;
               best_idx_d = cand_idx;
               grp_d      = grp_q + GRP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            row_q[i]   <= '0;
            cnt_q[i]   <= '0;
         end
         spill_q     <= '0;
         alarm_q     <= 1'b0;
         state_q     <= ST_IDLE;
         grp_q       <= '0;
         best_cnt_q  <= '0;
         best_idx_q  <= '0;
         max_valid_q <= 1'b0;
         max_cnt_q   <= '0;
         max_idx_q   <= '0;
         max_row_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         spill_q     <= spill_d;
         alarm_q     <= alarm_d;
         state_q     <= state_d;
         grp_q       <= grp_d;
         best_cnt_q  <= best_cnt_d;
         best_idx_q  <= best_idx_d;
         max_valid_q <= max_valid_d;
         max_cnt_q   <= max_cnt_d;
         max_idx_q   <= max_idx_d;
         max_row_q   <= max_row_d;
      end
   end

   assign act_ready = ~busy;
   assign clr_ready = ~busy;
   assign max_busy  = busy;
   assign max_valid = max_valid_q;
   assign max_cnt   = max_cnt_q;
   assign max_idx   = max_idx_q;
   assign max_row   = max_row_q;
   assign spill_cnt = spill_q;
   assign alarm     = alarm_q;

endmodule

// File: tb/tb_rfm_cnt_table.sv
// ----------------------------------------------------------------------------
// tb_rfm_cnt_table
// Self-checking bench: table-driven vectors, directed corner sequences and a
// randomized phase, all compared against a behavioural model of the table.
// ----------------------------------------------------------------------------
module tb_rfm_cnt_table;
   import rfm_pkg::*;

   localparam int ENTRIES = 64;
   localparam int ROW_W   = 17;
   localparam int CNT_W   = 16;
   localparam int LANES   = 16;
   localparam int IDX_W   = 6;
   localparam int NPASS   = ENTRIES / LANES;
   localparam int THRESH  = 4096;
   localparam int CNT_MAX = 65535;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             act_valid = 1'b0;
   logic [ROW_W-1:0] act_row = '0;
   logic             act_ready;
   logic             max_req = 1'b0;
   logic             max_busy;
   logic             max_valid;
   logic [CNT_W-1:0] max_cnt;
   logic [IDX_W-1:0] max_idx;
   logic [ROW_W-1:0] max_row;
   logic             clr_en = 1'b0;
   logic [IDX_W-1:0] clr_idx = '0;
   logic             clr_ready;
   logic [CNT_W-1:0] spill_cnt;
   logic             alarm;

   always #5 clk = ~clk;

   rfm_cnt_table dut (
      .clk       (clk),
      .rstn      (rstn),
      .act_valid (act_valid),
      .act_row   (act_row),
      .act_ready (act_ready),
      .max_req   (max_req),
      .max_busy  (max_busy),
      .max_valid (max_valid),
      .max_cnt   (max_cnt),
      .max_idx   (max_idx),
      .max_row   (max_row),
      .clr_en    (clr_en),
      .clr_idx   (clr_idx),
      .clr_ready (clr_ready),
      .spill_cnt (spill_cnt),
      .alarm     (alarm)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- behavioural model ----------------
   entry_t m_tbl [ENTRIES];
   int     m_spill;
   bit     m_alarm, m_busy, m_pulse;
   int     m_left;
   int     m_res_cnt, m_res_idx, m_res_row;
   int     p_cnt, p_idx, p_row;

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_tbl[i] = '0;
      m_spill = 0; m_alarm = 0; m_busy = 0; m_pulse = 0; m_left = 0;
      m_res_cnt = 0; m_res_idx = 0; m_res_row = 0;
   endtask

   task automatic model_act(input logic [ROW_W-1:0] r);
      int hit = -1, free = -1, vict = -1;
      for (int i = 0; i < ENTRIES; i++) begin
         if (m_tbl[i].valid && m_tbl[i].row == r) hit = i;
         if (!m_tbl[i].valid && free < 0) free = i;
         if (m_tbl[i].valid && int'(m_tbl[i].cnt) == m_spill && vict < 0) vict = i;
      end
      if (hit >= 0) m_tbl[hit].cnt = 16'(sat(int'(m_tbl[hit].cnt) + 1));
      else if (free >= 0) m_tbl[free] = '{valid: 1'b1, row: r, cnt: 16'(sat(m_spill + 1))};
      else if (vict >= 0) m_tbl[vict] = '{valid: 1'b1, row: r, cnt: 16'(sat(m_spill + 1))};
      else m_spill = sat(m_spill + 1);
   endtask

   task automatic model_max();
      p_cnt = 0; p_idx = 0;
      for (int i = 0; i < ENTRIES; i++) begin
         int v = m_tbl[i].valid ? int'(m_tbl[i].cnt) : 0;
         if (v > p_cnt) begin p_cnt = v; p_idx = i; end
      end
      p_row = int'(m_tbl[p_idx].row);
   endtask

   task automatic model_edge();
      m_pulse = 0;
      if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 0; m_pulse = 1;
            m_res_cnt = p_cnt; m_res_idx = p_idx; m_res_row = p_row;
         end
      end else begin
         if (clr_en) m_tbl[clr_idx].cnt = '0;
         if (act_valid) model_act(act_row);
         if (max_req) begin
            m_busy = 1; m_left = NPASS;
            model_max();
         end
      end
      m_alarm = 0;
      for (int i = 0; i < ENTRIES; i++)
         if (m_tbl[i].valid && int'(m_tbl[i].cnt) >= THRESH) m_alarm = 1;
   endtask

   task automatic compare_all();
      chk("act_ready", 64'(act_ready), 64'(!m_busy));
      chk("clr_ready", 64'(clr_ready), 64'(!m_busy));
      chk("max_busy",  64'(max_busy),  64'(m_busy));
      chk("max_valid", 64'(max_valid), 64'(m_pulse));
      chk("spill_cnt", 64'(spill_cnt), 64'(m_spill));
      chk("alarm",     64'(alarm),     64'(m_alarm));
      chk("max_cnt",   64'(max_cnt),   64'(m_res_cnt));
      chk("max_idx",   64'(max_idx),   64'(m_res_idx));
      chk("max_row",   64'(max_row),   64'(m_res_row));
   endtask

   // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
   task automatic step(input bit av, input logic [ROW_W-1:0] r, input bit ce,
                       input logic [IDX_W-1:0] ci, input bit req);
      act_valid = av; act_row = r; clr_en = ce; clr_idx = ci; max_req = req;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic act(input logic [ROW_W-1:0] r);
      step(1'b1, r, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      act_valid = 0; clr_en = 0; max_req = 0;
      rstn = 1'b0;
      model_reset();
      #3;
      chk("rst_busy",  64'(max_busy),  64'(0));
      chk("rst_valid", 64'(max_valid), 64'(0));
      chk("rst_spill", 64'(spill_cnt), 64'(0));
      chk("rst_alarm", 64'(alarm),     64'(0));
      chk("rst_cnt",   64'(max_cnt),   64'(0));
      @(negedge clk);
      rstn = 1'b1;
      idle();
   endtask

   // Issues a request and checks the pulse arrives exactly NPASS cycles later.
   task automatic search(input string name);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      repeat (NPASS - 1) begin
         idle();
         chk({name, "_early"}, 64'(max_valid), 64'(0));
      end
      idle();
      chk({name, "_pulse"}, 64'(max_valid), 64'(1));
   endtask

   typedef struct {
      bit               av;
      logic [ROW_W-1:0] row;
      bit               req;
      bit               e_busy;
      bit               e_valid;
   } vec_t;

   vec_t tv [$];
   int   low_cycles;

   initial begin
      // Vector table: 5x row 0x100, 3x row 0x200, request, then the search.
      for (int i = 0; i < 5; i++) tv.push_back('{1'b1, 17'h100, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++) tv.push_back('{1'b1, 17'h200, 1'b0, 1'b0, 1'b0});
      tv.push_back('{1'b0, 17'h0, 1'b1, 1'b1, 1'b0});
      for (int i = 0; i < 3; i++) tv.push_back('{1'b0, 17'h0, 1'b0, 1'b1, 1'b0});
      tv.push_back('{1'b0, 17'h0, 1'b0, 1'b0, 1'b1});
      tv.push_back('{1'b0, 17'h0, 1'b0, 1'b0, 1'b0});

      do_reset();
      foreach (tv[i]) begin
         step(tv[i].av, tv[i].row, 1'b0, '0, tv[i].req);
         chk("t1_busy",  64'(max_busy),  64'(tv[i].e_busy));
         chk("t1_valid", 64'(max_valid), 64'(tv[i].e_valid));
      end
      chk("t1_cnt",   64'(max_cnt),   64'(5));
      chk("t1_idx",   64'(max_idx),   64'(0));
      chk("t1_row",   64'(max_row),   64'(17'h100));
      chk("t1_spill", 64'(spill_cnt), 64'(0));

      // Full table: new row spills, next new row replaces entry 0.
      do_reset();
      for (int i = 0; i < ENTRIES; i++) act(ROW_W'(32'h1000 + i));
      act(17'h2000);
      chk("t2_spill1", 64'(spill_cnt), 64'(1));
      act(17'h2001);
      chk("t2_spill_hold", 64'(spill_cnt), 64'(1));
      search("t2_search");
      chk("t2_cnt", 64'(max_cnt), 64'(2));
      chk("t2_idx", 64'(max_idx), 64'(0));
      chk("t2_row", 64'(max_row), 64'(17'h2001));

      // Tie between entries 3 and 40, then clear 3.
      do_reset();
      for (int i = 0; i < ENTRIES; i++) act(ROW_W'(32'h3000 + i));
      repeat (6) act(17'h3003);
      repeat (6) act(17'h3028);
      search("t3_tie");
      chk("t3_tie_idx", 64'(max_idx), 64'(3));
      chk("t3_tie_cnt", 64'(max_cnt), 64'(7));
      step(1'b0, '0, 1'b1, 6'd3, 1'b0);
      search("t3_clr");
      chk("t3_clr_idx", 64'(max_idx), 64'(40));
      chk("t3_clr_cnt", 64'(max_cnt), 64'(7));
      chk("t3_clr_row", 64'(max_row), 64'(17'h3028));

      // Table frozen while busy: ACT and clr held high during a search.
      do_reset();
      for (int i = 0; i < 6; i++) act(ROW_W'(32'h4000 + i));
      repeat (2) act(17'h4005);
      low_cycles = 0;
      step(1'b1, 17'h4100, 1'b0, '0, 1'b1);
      if (!act_ready) low_cycles++;
      for (int i = 0; i < NPASS; i++) begin
         step(1'b1, 17'h4100, (i < NPASS - 1), 6'd5, 1'b0);
         if (!act_ready) low_cycles++;
      end
      idle();
      chk("t4_ready_low_cycles", 64'(low_cycles), 64'(NPASS));
      chk("t4_first_idx", 64'(max_idx), 64'(5));
      search("t4_again");
      chk("t4_e5_cnt", 64'(max_cnt), 64'(3));
      chk("t4_e5_idx", 64'(max_idx), 64'(5));

      // Clear and hit on the same entry in one cycle.
      do_reset();
      act(17'h5000); act(17'h5001);
      repeat (9) act(17'h5002);
      step(1'b0, '0, 1'b1, 6'd0, 1'b0);
      step(1'b0, '0, 1'b1, 6'd1, 1'b0);
      step(1'b1, 17'h5002, 1'b1, 6'd2, 1'b0);
      search("t5_clrhit");
      chk("t5_cnt", 64'(max_cnt), 64'(1));
      chk("t5_idx", 64'(max_idx), 64'(2));

      // Alarm at THRESH and its release after a clear.
      do_reset();
      repeat (THRESH - 1) act(17'h6000);
      chk("t5_alarm_below", 64'(alarm), 64'(0));
      act(17'h6000);
      chk("t5_alarm_at", 64'(alarm), 64'(1));
      step(1'b0, '0, 1'b1, 6'd0, 1'b0);
      chk("t5_alarm_clr", 64'(alarm), 64'(0));

      // Reset in the middle of a search.
      do_reset();
      repeat (3) act(17'h7000);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      idle();
      rstn = 1'b0;
      #1;
      chk("t6_busy",  64'(max_busy),  64'(0));
      chk("t6_valid", 64'(max_valid), 64'(0));
      chk("t6_cnt",   64'(max_cnt),   64'(0));
      chk("t6_idx",   64'(max_idx),   64'(0));
      chk("t6_row",   64'(max_row),   64'(0));
      chk("t6_spill", 64'(spill_cnt), 64'(0));
      chk("t6_alarm", 64'(alarm),     64'(0));
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      repeat (NPASS + 1) idle();
      search("t6_after");
      chk("t6_after_cnt", 64'(max_cnt), 64'(0));
      chk("t6_after_idx", 64'(max_idx), 64'(0));

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) < 70,
              ROW_W'(32'h8000 + $urandom_range(0, 79)),
              $urandom_range(0, 99) < 8,
              IDX_W'($urandom_range(0, ENTRIES - 1)),
              $urandom_range(0, 99) < 6);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
